// File: rtl/benes_pkg.sv
// Shared constants, stage-bit mapping, drain FSM states and PRNG helpers for
// the pipelined Benes permutation network.
package benes_pkg;

  function automatic int benes_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int benes_nstg(input int w);
    return 2 * benes_log2(w) - 1;
  endfunction

  function automatic int benes_nbits(input int w);
    return w * benes_log2(w) - w / 2;
  endfunction

  // Butterfly bit for stage s: descend L-1..0, then climb back up to L-1.
  function automatic int benes_stage_bit(input int s, input int l);
    return (s < l) ? (l - 1 - s) : (s - l + 1);
  endfunction

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } benes_state_e;

  localparam logic [31:0] PRNG_SEED = 32'h2545F491;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/benes_stage.sv
// One Benes switch column: WIDTH/2 two-way switches on butterfly bit B,
// followed by the stage's data/valid register.
module benes_stage #(
  parameter int WIDTH = 8,
  parameter int DW    = 8,
  parameter int B     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [WIDTH*DW-1:0]   i_data,
  input  logic [WIDTH/2-1:0]    i_sw,
  output logic                  o_valid,
  output logic [WIDTH*DW-1:0]   o_data
);

  logic [WIDTH*DW-1:0] w_sw_data;

  // Element gi belongs to switch J (index with bit B removed); its partner is gi^(1<<B).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_el
    localparam int J = ((gi >> (B + 1)) << B) | (gi & ((1 << B) - 1));
    localparam int P = gi ^ (1 << B);
    assign w_sw_data[gi*DW +: DW] = i_sw[J] ? i_data[P*DW +: DW] : i_data[gi*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_data  <= w_sw_data;
    end
  end

endmodule

// File: rtl/benes_perm_pipe.sv
// Fully pipelined Benes permutation network with valid/ready stream, shadow
// control register and flush/drain FSM. Optional macro: BENES_PRNG_EN.
module benes_perm_pipe
  import benes_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DW    = 8,
  localparam int L     = benes_log2(WIDTH),
  localparam int NSTG  = 2 * L - 1,
  localparam int NBITS = WIDTH * L - WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*DW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*DW-1:0]   out_data,
  input  logic                  cfg_valid,
  input  logic [NBITS-1:0]      cfg_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef BENES_PRNG_EN
  ,
  input  logic                  cfg_rand
`endif
);

  localparam int HW = WIDTH / 2;

  // Handshake: a beat moves on a clock edge where valid && ready; the whole
  // pipe shifts only when the output register is empty or being drained.
  benes_state_e        r_state, w_state_nxt;
  logic                r_pulsed;
  logic [NBITS-1:0]    r_shadow;
  logic [NBITS-1:0]    w_beat_ctrl;
  logic [NSTG-1:0]     w_valid;
  logic [WIDTH*DW-1:0] w_data [NSTG];
  logic                w_adv;
  logic                w_accept;

  assign w_adv     = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = w_valid[NSTG-1];
  assign out_data  = w_data[NSTG-1];
  assign busy      = |w_valid;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else if (cfg_valid) r_shadow <= cfg_data;
  end

`ifdef BENES_PRNG_EN
  localparam int NG = (NBITS + 31) / 32;
  logic [32*NG-1:0] r_prng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NG; k++) r_prng[k*32 +: 32] <= PRNG_SEED + 32'(k);
    end else if (w_accept && cfg_rand) begin
      for (int k = 0; k < NG; k++) r_prng[k*32 +: 32] <= xorshift32(r_prng[k*32 +: 32]);
    end
  end

  assign w_beat_ctrl = cfg_rand ? r_prng[NBITS-1:0] : (cfg_valid ? cfg_data : r_shadow);
`else
  assign w_beat_ctrl = cfg_valid ? cfg_data : r_shadow;
`endif

  // Each beat's control travels with it; already-consumed slices are dropped.
  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int RW = (NSTG - s) * HW;
    logic [RW-1:0]       w_cin;
    logic                w_vin;
    logic [WIDTH*DW-1:0] w_din;

    if (s == 0) begin : g_first
      assign w_cin = w_beat_ctrl;
      assign w_vin = w_accept;
      assign w_din = in_data;
    end else begin : g_next
      assign w_cin = g_stg[s-1].g_carry.r_cout;
      assign w_vin = w_valid[s-1];
      assign w_din = w_data[s-1];
    end

    benes_stage #(
      .WIDTH (WIDTH),
      .DW    (DW),
      .B     (benes_stage_bit(s, L))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_vin),
      .i_data  (w_din),
      .i_sw    (w_cin[HW-1:0]),
      .o_valid (w_valid[s]),
      .o_data  (w_data[s])
    );

    if (s < NSTG - 1) begin : g_carry
      logic [RW-HW-1:0] r_cout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cout <= '0;
        else if (w_adv) r_cout <= w_cin[RW-1:HW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_pulsed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pulsed <= (r_state == DONE);
    end
  end

  // r_pulsed limits flush_done to the first DONE cycle while flush stays high.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      RUN: begin
        in_ready = w_adv;
        if (flush) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!busy) w_state_nxt = DONE;
      end
      DONE: begin
        flush_done = !r_pulsed;
        if (!flush) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

endmodule
